// File: rtl/seq_gen_if.sv
// Bus bundle for the serial pattern generator.
// master: drives start/abort/pattern/pat_len/repeat_n/gap and
// observes x_out/x_valid/busy/done; slave: the generator side.
interface seq_gen_if #(
    parameter int PAT_W = 8,
    parameter int LEN_W = 4,
    parameter int CNT_W = 8,
    parameter int GAP_W = 4
);
    logic             start;
    logic             abort;
    logic [PAT_W-1:0] pattern;
    logic [LEN_W-1:0] pat_len;
    logic [CNT_W-1:0] repeat_n;
    logic [GAP_W-1:0] gap;
    logic             x_out;
    logic             x_valid;
    logic             busy;
    logic             done;

    modport master (
        output start, abort, pattern, pat_len, repeat_n, gap,
        input  x_out, x_valid, busy, done
    );

    modport slave (
        input  start, abort, pattern, pat_len, repeat_n, gap,
        output x_out, x_valid, busy, done
    );
endinterface

// File: rtl/seq_gen.sv
// Serial pattern generator: shifts a 1..PAT_W bit pattern out MSB first,
// repeated repeat_n times with gap idle cycles between repetitions.
// Ports: clk, rst (async, active-high), bus (seq_gen_if.slave).
module seq_gen #(
    parameter int PAT_W = 8,
    parameter int LEN_W = 4,
    parameter int CNT_W = 8,
    parameter int GAP_W = 4
) (
    input  logic     clk,
    input  logic     rst,
    seq_gen_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;

    state_t           state;
    logic [PAT_W-1:0] pat_sh;
    logic [PAT_W-1:0] sr;
    logic [PAT_W-1:0] pat_c;
    logic [LEN_W-1:0] len_sh;
    logic [LEN_W-1:0] len_c;
    logic [LEN_W-1:0] idx;
    logic [CNT_W-1:0] reps;
    logic [GAP_W-1:0] gap_sh;
    logic [GAP_W-1:0] gcnt;

    assign len_c = (bus.pat_len > LEN_W'(PAT_W)) ? LEN_W'(PAT_W)
                                                 : bus.pat_len;

    // Left-align the active bits so the next bit is always the MSB
    assign pat_c = bus.pattern << (PAT_W - int'(len_c));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            pat_sh      <= '0;
            sr          <= '0;
            len_sh      <= '0;
            idx         <= '0;
            reps        <= '0;
            gap_sh      <= '0;
            gcnt        <= '0;
            bus.x_out   <= 1'b0;
            bus.x_valid <= 1'b0;
            bus.busy    <= 1'b0;
            bus.done    <= 1'b0;
        end else if (state != IDLE && bus.abort) begin
            state       <= IDLE;
            bus.x_out   <= 1'b0;
            bus.x_valid <= 1'b0;
            bus.busy    <= 1'b0;
            bus.done    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        pat_sh   <= pat_c;
                        sr       <= pat_c;
                        len_sh   <= len_c;
                        reps     <= bus.repeat_n;
                        gap_sh   <= bus.gap;
                        gcnt     <= '0;
                        bus.busy <= 1'b1;
                        if (len_c == '0 || bus.repeat_n == '0) begin
                            state       <= DONE;
                            idx         <= '0;
                            bus.done    <= 1'b1;
                            bus.x_valid <= 1'b0;
                            bus.x_out   <= 1'b0;
                        end else begin
                            state       <= SEND;
                            idx         <= len_c - LEN_W'(1);
                            bus.done    <= 1'b0;
                            bus.x_valid <= 1'b1;
                            bus.x_out   <= pat_c[PAT_W-1];
                        end
                    end
                end
                SEND: begin
                    if (idx != '0) begin
                        idx       <= idx - LEN_W'(1);
                        sr        <= sr << 1;
                        bus.x_out <= sr[PAT_W-2];
                    end else if (reps > CNT_W'(1)) begin
                        if (gap_sh == '0) begin
                            // back-to-back repetition, no bubble
                            sr        <= pat_sh;
                            idx       <= len_sh - LEN_W'(1);
                            reps      <= reps - CNT_W'(1);
                            bus.x_out <= pat_sh[PAT_W-1];
                        end else begin
                            state       <= GAP;
                            gcnt        <= gap_sh;
                            bus.x_valid <= 1'b0;
                            bus.x_out   <= 1'b0;
                        end
                    end else begin
                        state       <= DONE;
                        bus.x_valid <= 1'b0;
                        bus.x_out   <= 1'b0;
                        bus.done    <= 1'b1;
                    end
                end
                GAP: begin
                    // gcnt holds the idle cycles still to show, this one included
                    if (gcnt <= GAP_W'(1)) begin
                        state       <= SEND;
                        gcnt        <= '0;
                        sr          <= pat_sh;
                        idx         <= len_sh - LEN_W'(1);
                        reps        <= reps - CNT_W'(1);
                        bus.x_valid <= 1'b1;
                        bus.x_out   <= pat_sh[PAT_W-1];
                    end else begin
                        gcnt <= gcnt - GAP_W'(1);
                    end
                end
                DONE: begin
                    state       <= IDLE;
                    bus.busy    <= 1'b0;
                    bus.done    <= 1'b0;
                    bus.x_valid <= 1'b0;
                    bus.x_out   <= 1'b0;
                end
                default: begin
                    state       <= IDLE;
                    bus.busy    <= 1'b0;
                    bus.done    <= 1'b0;
                    bus.x_valid <= 1'b0;
                    bus.x_out   <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_seq_gen.sv
// Testbench for seq_gen: directed vector table plus hand-written
// abort / reset sequences; a 1011 detector model watches the stream.
module tb_seq_gen;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    seq_gen_if #(.PAT_W(8), .LEN_W(4), .CNT_W(8), .GAP_W(4)) bus ();

    seq_gen #(.PAT_W(8), .LEN_W(4), .CNT_W(8), .GAP_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic [7:0] pattern;
        logic [3:0] pat_len;
        logic [7:0] repeat_n;
        logic [3:0] gap;
        string      stream;
        bit         det;
    } vec_t;

    vec_t vecs[8];
    int   n_chk  = 0;
    int   n_fail = 0;
    logic [3:0] shreg;
    bit         det;

    // {busy, done, x_valid, x_out}
    function automatic logic [3:0] obs();
        return {bus.busy, bus.done, bus.x_valid, bus.x_out};
    endfunction

    task automatic check(input string name, input logic [3:0] act,
                         input logic [3:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b (busy,done,valid,x)",
                     name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input bit act,
                             input bit exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b, expected %0b", name, act, exp);
        end
    endtask

    // 1011 detector model over valid bits only
    task automatic watch();
        if (bus.x_valid) begin
            shreg = {shreg[2:0], bus.x_out};
            if (shreg == 4'b1011) det = 1'b1;
        end
    endtask

    task automatic scramble();
        bus.pattern  = 8'($urandom);
        bus.pat_len  = 4'($urandom);
        bus.repeat_n = 8'($urandom);
        bus.gap      = 4'($urandom);
    endtask

    // Called at edge+1; start edge is the next posedge
    task automatic run_vec(input int k);
        int d;
        logic [3:0] exp;
        string nm;
        d = vecs[k].stream.len() + 1;
        shreg = 4'b0000;
        det = 1'b0;
        bus.pattern  = vecs[k].pattern;
        bus.pat_len  = vecs[k].pat_len;
        bus.repeat_n = vecs[k].repeat_n;
        bus.gap      = vecs[k].gap;
        bus.start    = 1'b1;
        @(posedge clk);
        #1;
        for (int c = 1; c <= d; c++) begin
            if (c > 1) begin
                @(posedge clk);
                #1;
            end
            if (c == d) begin
                exp = 4'b1100;
            end else begin
                case (vecs[k].stream[c-1])
                    "1":     exp = 4'b1011;
                    "0":     exp = 4'b1010;
                    default: exp = 4'b1000;
                endcase
            end
            nm = $sformatf("vec%0d_cyc%0d", k, c);
            check(nm, obs(), exp);
            watch();
            // inputs and start are free to change while busy
            scramble();
            bus.start = (c < d) ? 1'($urandom) : 1'b0;
        end
        @(posedge clk);
        #1;
        check($sformatf("vec%0d_idle", k), obs(), 4'b0000);
        check_bit($sformatf("vec%0d_det", k), det, vecs[k].det);
    endtask

    initial begin
        vecs[0] = '{8'h0B, 4'd4,  8'd1, 4'd0, "1011",         1'b1};
        vecs[1] = '{8'h0B, 4'd4,  8'd2, 4'd2, "1011--1011",   1'b1};
        vecs[2] = '{8'h0B, 4'd4,  8'd3, 4'd0, "101110111011", 1'b1};
        vecs[3] = '{8'h0B, 4'd4,  8'd0, 4'd0, "",             1'b0};
        vecs[4] = '{8'h0B, 4'd0,  8'd3, 4'd0, "",             1'b0};
        vecs[5] = '{8'hA5, 4'd12, 8'd1, 4'd0, "10100101",     1'b0};
        vecs[6] = '{8'h06, 4'd3,  8'd2, 4'd1, "110-110",      1'b1};
        vecs[7] = '{8'h80, 4'd8,  8'd1, 4'd3, "10000000",     1'b0};

        bus.start = 1'b0;
        bus.abort = 1'b0;
        scramble();

        #12;
        check("reset", obs(), 4'b0000);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_reset_idle", obs(), 4'b0000);

        for (int k = 0; k < 8; k++) run_vec(k);

        // abort in cycle 2 of a single 1011 send
        bus.pattern  = 8'h0B;
        bus.pat_len  = 4'd4;
        bus.repeat_n = 8'd1;
        bus.gap      = 4'd0;
        bus.start    = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check("abort_c1", obs(), 4'b1011);
        @(posedge clk);
        #1;
        check("abort_c2", obs(), 4'b1010);
        bus.abort = 1'b1;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.abort = 1'b0;
        bus.start = 1'b0;
        check("abort_c3", obs(), 4'b0000);
        for (int c = 4; c <= 7; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("abort_c%0d", c), obs(), 4'b0000);
        end
        run_vec(0);

        // async reset during SEND
        bus.pattern  = 8'h0B;
        bus.pat_len  = 4'd4;
        bus.repeat_n = 8'd3;
        bus.gap      = 4'd0;
        bus.start    = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check("rst_c1", obs(), 4'b1011);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("rst_async", obs(), 4'b0000);
        #1;
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("rst_after%0d", c), obs(), 4'b0000);
        end
        run_vec(6);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
